// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures the high time and period of an asynchronous PWM
// line in clk cycles, and decodes the duty cycle into a 4-bit mode code
// (mode = min(15, floor(16*high/period))). A line that stops toggling is
// reported as stuck_high / stuck_low after TIMEOUT edge-free cycles.
//
// Output handshake: valid is a single-cycle pulse. high_count, period_count,
// mode, stuck_high and stuck_low change only in the cycle valid rises and hold
// their values until the next valid pulse. There is no back-pressure.
module pwm_duty_decoder #(
  parameter int          CNT_W   = 16,
  parameter int unsigned TIMEOUT = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_count,
  output logic [CNT_W-1:0] period_count,
  output logic [3:0]       mode,
  output logic             valid,
  output logic             stuck_high,
  output logic             stuck_low
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // Measurement FSM state; kept as a named signal so checkers can bind to it.
  state_t state;
  state_t state_next;

  logic             sync_1;
  logic             s;
  logic             s_d;
  logic             rise;
  logic             fall;

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] tcnt;
  logic             tcnt_fire;

  logic             snap;
  logic             cnt_start;
  logic             cnt_run;

  logic             div_busy;
  logic [1:0]       div_step;
  logic [CNT_W:0]   div_r;
  logic [CNT_W-1:0] div_p;
  logic [CNT_W-1:0] div_h;
  logic [3:0]       div_q;
  logic             div_clamp;
  logic [CNT_W:0]   r_sh;
  logic [CNT_W:0]   p_ext;
  logic             div_bit;
  logic [CNT_W:0]   r_next;

  // Two-flop synchronizer plus one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_1 <= 1'b0;
      s      <= 1'b0;
      s_d    <= 1'b0;
    end else begin
      sync_1 <= pwm_in;
      s      <= sync_1;
      s_d    <= s;
    end
  end

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // Edge-free cycle counter; fires once when it first reaches TIMEOUT and then
  // parks there so a line that stays stuck does not re-report.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tcnt <= '0;
    end else if (rise || fall) begin
      tcnt <= '0;
    end else if (tcnt != TO_C) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign tcnt_fire = !(rise || fall) && (tcnt == TO_M1);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; a timeout always drops back to IDLE so the next
  // reported period starts from a fresh rising edge.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (rise) state_next = ST_HIGH;
      ST_HIGH: if (fall) state_next = ST_LOW;
      ST_LOW:  if (rise) state_next = ST_HIGH;
      default: state_next = ST_IDLE;
    endcase
    if (tcnt_fire) state_next = ST_IDLE;
  end

  // FSM outputs: counter control and the snapshot strobe that closes a period.
  always_comb begin
    snap      = (state == ST_LOW) && rise;
    cnt_start = rise && (state != ST_HIGH);
    cnt_run   = (state != ST_IDLE);
  end

  // High-time and period counters; they saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hcnt <= '0;
      pcnt <= '0;
    end else if (cnt_start) begin
      hcnt <= CNT_W'(1);
      pcnt <= CNT_W'(1);
    end else if (cnt_run) begin
      if (pcnt != CNT_MAX) pcnt <= pcnt + 1'b1;
      if ((state == ST_HIGH) && s && (hcnt != CNT_MAX)) hcnt <= hcnt + 1'b1;
    end
  end

  // One restoring-division step: shift the partial remainder, try to subtract.
  always_comb begin
    r_sh    = div_r << 1;
    p_ext   = {1'b0, div_p};
    div_bit = (r_sh >= p_ext);
    r_next  = div_bit ? (r_sh - p_ext) : r_sh;
  end

  // Four-step divider; a new snapshot always reloads it, dropping any older
  // divide still in flight. A timeout cancels a pending divide.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_busy  <= 1'b0;
      div_step  <= 2'd0;
      div_r     <= '0;
      div_p     <= '0;
      div_h     <= '0;
      div_q     <= 4'd0;
      div_clamp <= 1'b0;
    end else if (snap) begin
      div_busy  <= 1'b1;
      div_step  <= 2'd3;
      div_r     <= {1'b0, hcnt};
      div_p     <= pcnt;
      div_h     <= hcnt;
      div_q     <= 4'd0;
      div_clamp <= (hcnt >= pcnt);
    end else if (tcnt_fire) begin
      div_busy <= 1'b0;
    end else if (div_busy) begin
      div_r           <= r_next;
      div_q[div_step] <= div_bit;
      div_step        <= div_step - 2'd1;
      if (div_step == 2'd0) div_busy <= 1'b0;
    end
  end

  // Result registers: load on divider completion or on a timeout event.
  always_ff @(posedge clk) begin
    if (!rst) begin
      high_count   <= '0;
      period_count <= '0;
      mode         <= 4'd0;
      valid        <= 1'b0;
      stuck_high   <= 1'b0;
      stuck_low    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (tcnt_fire) begin
        valid        <= 1'b1;
        period_count <= TO_C;
        if (s) begin
          stuck_high <= 1'b1;
          stuck_low  <= 1'b0;
          mode       <= 4'd15;
          high_count <= TO_C;
        end else begin
          stuck_high <= 1'b0;
          stuck_low  <= 1'b1;
          mode       <= 4'd0;
          high_count <= '0;
        end
      end else if (div_busy && (div_step == 2'd0)) begin
        valid        <= 1'b1;
        high_count   <= div_h;
        period_count <= div_p;
        mode         <= div_clamp ? 4'd15 : {div_q[3:1], div_bit};
        stuck_high   <= 1'b0;
        stuck_low    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: drives PWM waveforms (directed and random) into
// pwm_duty_decoder. A reference model samples the line the way the DUT does
// and derives each expected report from the sequence of sampled levels; a
// monitor pops the expected queue on every valid pulse.
module tb_pwm_duty_decoder;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 100;
  localparam int EXP_W   = CNT_W + CNT_W + 4 + 1 + 1 + 32;

  logic             clk;
  logic             rst;
  logic             pwm_in;
  logic [CNT_W-1:0] high_count;
  logic [CNT_W-1:0] period_count;
  logic [3:0]       mode;
  logic             valid;
  logic             stuck_high;
  logic             stuck_low;

  // {high_count, period_count, mode, stuck_high, stuck_low, expected cycle}
  // expected cycle 0 means the arrival cycle is not checked.
  logic [EXP_W-1:0] exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  pwm_duty_decoder #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pwm_in       (pwm_in),
    .high_count   (high_count),
    .period_count (period_count),
    .mode         (mode),
    .valid        (valid),
    .stuck_high   (stuck_high),
    .stuck_low    (stuck_low)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded 60000 cycles, required completion");
    $fatal(1, "watchdog expired");
  end

  // Reference model: works on the level sampled at each clock edge. A period
  // runs from one sampled rise to the next; the first rise after reset or a
  // timeout only arms the measurement. Reports land 6 edges after the closing
  // rise; a report whose successor rise comes less than 4 edges later is
  // replaced by it. A constant run of TIMEOUT samples is a stuck line.
  initial begin : ref_model
    bit p;
    bit prev;
    bit armed;
    int hi;
    int run;
    int per;
    int md;
    int last_rise;
    int last_push;
    prev = 1'b0; armed = 1'b0; hi = 0; run = 0; last_rise = 0; last_push = -100;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        exp_q.delete();
        prev = 1'b0; armed = 1'b0; hi = 0; run = 0; last_push = -100;
      end else begin
        p = pwm_in;
        if (p && !prev) begin
          if (armed) begin
            per = cyc - last_rise;
            md  = (16 * hi) / per;
            if (md > 15) md = 15;
            if (exp_q.size() > 0 && (cyc - last_push) < 4) void'(exp_q.pop_back());
            exp_q.push_back({CNT_W'(hi), CNT_W'(per), 4'(md), 1'b0, 1'b0, 32'(cyc + 6)});
            last_push = cyc;
          end
          armed = 1'b1;
          last_rise = cyc;
          hi = 0;
        end
        if (p) hi++;
        if (p == prev) run++;
        else run = 1;
        if (run == TIMEOUT) begin
          if (p) exp_q.push_back({CNT_W'(TIMEOUT), CNT_W'(TIMEOUT), 4'd15, 1'b1, 1'b0, 32'd0});
          else   exp_q.push_back({CNT_W'(0), CNT_W'(TIMEOUT), 4'd0, 1'b0, 1'b1, 32'd0});
          armed = 1'b0;
        end
        prev = p;
      end
    end
  end

  // Monitor / scoreboard: every valid pulse must match the oldest expectation.
  initial begin : monitor
    logic [EXP_W-1:0] e;
    logic [EXP_W-33:0] got;
    forever begin
      @(negedge clk);
      if (valid) begin
        n_tests++;
        got = {high_count, period_count, mode, stuck_high, stuck_low};
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid @%0d: got hc=%0d pc=%0d mode=%0d sh=%0b sl=%0b, required no valid",
                   cyc, high_count, period_count, mode, stuck_high, stuck_low);
        end else begin
          e = exp_q.pop_front();
          if (got !== e[EXP_W-1:32]) begin
            n_fail++;
            $display("FAIL report @%0d: got hc=%0d pc=%0d mode=%0d sh=%0b sl=%0b, required hc=%0d pc=%0d mode=%0d sh=%0b sl=%0b",
                     cyc, high_count, period_count, mode, stuck_high, stuck_low,
                     e[EXP_W-1 -: CNT_W], e[EXP_W-CNT_W-1 -: CNT_W], e[37:34], e[33], e[32]);
          end
          if (e[31:0] != 32'd0) begin
            n_tests++;
            if (cyc != int'(e[31:0])) begin
              n_fail++;
              $display("FAIL latency: valid at cycle %0d, required cycle %0d", cyc, e[31:0]);
            end
          end
        end
      end
    end
  end

  // Driver tasks.
  task automatic drive_period(input int h, input int l);
    repeat (h) begin @(negedge clk); pwm_in = 1'b1; end
    repeat (l) begin @(negedge clk); pwm_in = 1'b0; end
  endtask

  task automatic hold_level(input logic v, input int n);
    repeat (n) begin @(negedge clk); pwm_in = v; end
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if ({high_count, period_count, mode, valid, stuck_high, stuck_low} !== '0) begin
      n_fail++;
      $display("FAIL %s: got hc=%0d pc=%0d mode=%0d valid=%0b sh=%0b sl=%0b, required all 0",
               name, high_count, period_count, mode, valid, stuck_high, stuck_low);
    end
  endtask

  // Stimulus sequence.
  initial begin : stimulus
    rst = 1'b0;
    pwm_in = 1'b0;

    // Reset held with a toggling line: nothing may be reported.
    repeat (5) begin @(negedge clk); pwm_in = ~pwm_in; end
    check_zero("reset_hold");
    @(negedge clk); pwm_in = 1'b0; rst = 1'b1;
    hold_level(1'b0, 5);

    // Periodic 10 high / 20 low.
    repeat (5) drive_period(10, 20);

    // Near-100%, low and half duty cycles.
    drive_period(31, 1);
    drive_period(1, 15);
    drive_period(8, 8);
    drive_period(10, 20);

    // Random periods.
    repeat (16) drive_period(int'($urandom_range(1, 30)), int'($urandom_range(3, 30)));
    drive_period(10, 20);

    // Stuck high after valid periods, then recovery.
    drive_period(10, 20);
    hold_level(1'b1, 150);
    hold_level(1'b0, 20);
    repeat (3) drive_period(10, 20);

    // Back-to-back 3-cycle periods: only the last snapshot is reported.
    repeat (10) drive_period(1, 2);
    hold_level(1'b0, 12);

    // Reset in the middle of a divide.
    drive_period(1, 2);
    @(negedge clk); pwm_in = 1'b1;
    @(negedge clk); pwm_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset_mid_divide");
    rst = 1'b1;
    hold_level(1'b0, 20);

    // Line low straight out of reset: exactly one stuck_low report.
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_before_stuck_low");
    rst = 1'b1;
    hold_level(1'b0, 250);

    n_tests++;
    if (stuck_low !== 1'b1 || stuck_high !== 1'b0 || mode !== 4'd0) begin
      n_fail++;
      $display("FAIL stuck_low_hold: got sl=%0b sh=%0b mode=%0d, required sl=1 sh=0 mode=0",
               stuck_low, stuck_high, mode);
    end

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_reports: %0d expected reports never arrived, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
